// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared width, FSM encoding and clog2 helper for the GCD dispatcher
package gcd_pkg;

  localparam int GCD_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// rtl/gcd_pair_fifo.sv - operand-pair FIFO, first word visible combinationally
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter int DATA_W = GCD_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [2*DATA_W-1:0]   i_wdata,
  input  logic                  i_pop,
  output logic [2*DATA_W-1:0]   o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/greatest_common_divisor.sv
// rtl/greatest_common_divisor.sv - subtractive GCD core: WAIT -> CALC -> FINISH (done pulse)
module Greatest_Common_Divisor
  import gcd_pkg::*;
#(
  parameter int DATA_W = GCD_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_gcd
);

  typedef enum logic [1:0] {
    C_WAIT   = 2'b00,
    C_CALC   = 2'b01,
    C_FINISH = 2'b10
  } core_state_t;

  core_state_t       r_state;
  core_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic              w_settled;

  assign w_settled = (r_x == '0) || (r_y == '0) || (r_x == r_y);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= C_WAIT;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == C_WAIT && i_start) begin
        r_x <= i_a;
        r_y <= i_b;
      end else if (r_state == C_CALC && !w_settled) begin
        if (r_x > r_y) r_x <= r_x - r_y;
        else           r_y <= r_y - r_x;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_gcd       = '0;
    case (r_state)
      C_WAIT:   if (i_start) w_state_nxt = C_CALC;
      C_CALC:   if (w_settled) w_state_nxt = C_FINISH;
      C_FINISH: begin
        o_done      = 1'b1;
        // A zero operand leaves the other one as the answer; gcd(0,0)=0.
        o_gcd       = (r_x == '0) ? r_y : r_x;
        w_state_nxt = C_WAIT;
      end
      default:  w_state_nxt = C_WAIT;
    endcase
  end

endmodule

// File: rtl/gcd_dispatch.sv
// rtl/gcd_dispatch.sv - buffers operand pairs, issues one GCD job at a time, holds the result
// Optional: GCD_DISPATCH_BYPASS_EN returns pairs with a zero operand as a|b without using the core.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int DATA_W     = GCD_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [DATA_W-1:0]          i_in_a,
  input  logic [DATA_W-1:0]          i_in_b,
  output logic                       o_core_start,
  output logic [DATA_W-1:0]          o_core_a,
  output logic [DATA_W-1:0]          o_core_b,
  input  logic                       i_core_done,
  input  logic [DATA_W-1:0]          i_core_gcd,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_out_a,
  output logic [DATA_W-1:0]          o_out_b,
  output logic [DATA_W-1:0]          o_out_gcd,
  output logic [clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                       o_busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_core_a;
  logic [DATA_W-1:0]   r_core_b;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_a;
  logic [DATA_W-1:0]   r_out_b;
  logic [DATA_W-1:0]   r_out_gcd;

  logic [2*DATA_W-1:0] w_fifo_rdata;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   w_head_a;
  logic [DATA_W-1:0]   w_head_b;
  logic                w_pop;
  logic                w_job_to_core;
  logic                w_bypass_load;
  logic                w_core_result;
  logic                w_out_fire;
  logic                w_head_zero;

  gcd_pair_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_in_valid),
    .i_wdata ({i_in_a, i_in_b}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  assign w_head_a   = w_fifo_rdata[2*DATA_W-1:DATA_W];
  assign w_head_b   = w_fifo_rdata[DATA_W-1:0];
  assign w_out_fire = r_out_valid & i_out_ready;

`ifdef GCD_DISPATCH_BYPASS_EN
  assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);
`else
  assign w_head_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_job_to_core = 1'b0;
    w_bypass_load = 1'b0;
    w_core_result = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A draining result register counts as empty, so back-to-back jobs need no bubble.
        if (!w_fifo_empty && (!r_out_valid || w_out_fire)) begin
          w_pop = 1'b1;
          if (w_head_zero) begin
            w_bypass_load = 1'b1;
          end else begin
            w_job_to_core = 1'b1;
            w_state_nxt   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:     w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_core_done) begin
          w_core_result = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_core_a <= '0;
      r_core_b <= '0;
    end else if (w_job_to_core) begin
      r_core_a <= w_head_a;
      r_core_b <= w_head_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_gcd   <= '0;
    end else if (w_core_result) begin
      r_out_valid <= 1'b1;
      r_out_a     <= r_core_a;
      r_out_b     <= r_core_b;
      r_out_gcd   <= i_core_gcd;
    end else if (w_bypass_load) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_head_a;
      r_out_b     <= w_head_b;
      r_out_gcd   <= w_head_a | w_head_b;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready   = ~w_fifo_full;
  assign o_core_start = (r_state == ST_ISSUE);
  assign o_core_a     = r_core_a;
  assign o_core_b     = r_core_b;
  assign o_out_valid  = r_out_valid;
  assign o_out_a      = r_out_a;
  assign o_out_b      = r_out_b;
  assign o_out_gcd    = r_out_gcd;
  assign o_busy       = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb/tb_gcd_dispatch.sv - scoreboard bench for gcd_dispatch driving a Greatest_Common_Divisor core
module tb_gcd_dispatch;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_ready = 1'b0;
  logic          w_in_ready;
  logic          w_core_start;
  logic [DW-1:0] w_core_a;
  logic [DW-1:0] w_core_b;
  logic          w_core_done;
  logic [DW-1:0] w_core_gcd;
  logic          w_out_valid;
  logic [DW-1:0] w_out_a;
  logic [DW-1:0] w_out_b;
  logic [DW-1:0] w_out_gcd;
  logic [2:0]    w_fifo_count;
  logic          w_busy;

  always #5 clk = ~clk;

  gcd_dispatch #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (w_in_ready),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .o_core_start (w_core_start),
    .o_core_a     (w_core_a),
    .o_core_b     (w_core_b),
    .i_core_done  (w_core_done),
    .i_core_gcd   (w_core_gcd),
    .o_out_valid  (w_out_valid),
    .i_out_ready  (out_ready),
    .o_out_a      (w_out_a),
    .o_out_b      (w_out_b),
    .o_out_gcd    (w_out_gcd),
    .o_fifo_count (w_fifo_count),
    .o_busy       (w_busy)
  );

  Greatest_Common_Divisor #(.DATA_W(DW)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_core_start),
    .i_a     (w_core_a),
    .i_b     (w_core_b),
    .o_done  (w_core_done),
    .o_gcd   (w_core_gcd)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   starts = 0;
  int   inflight = 0;
  logic prev_start = 1'b0;

  function automatic logic [DW-1:0] ref_gcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[DW-1:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake; also polices core_start.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      inflight   = 0;
      prev_start = 1'b0;
    end else begin
      if (w_core_start) begin
        starts++;
        inflight++;
        check("start_one_cycle", int'(prev_start), 0);
        check("one_in_flight", int'(inflight <= 1), 1);
      end
      if (w_core_done) inflight--;
      prev_start = w_core_start;
      if (w_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got a=%0d b=%0d gcd=%0d want none", w_out_a, w_out_b, w_out_gcd);
        end else begin
          e = exp_q.pop_front();
          check("out_a", int'(w_out_a), int'(e.a));
          check("out_b", int'(w_out_b), int'(e.b));
          check("out_gcd", int'(w_out_gcd), int'(e.g));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; the expected result is queued on the accepting edge.
  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!w_in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!w_in_ready) begin
      check("push_timeout", 0, 1);
      @(posedge clk);
    end else begin
      @(posedge clk);
      e.a = a;
      e.b = b;
      e.g = ref_gcd(int'(a), int'(b));
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      step(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
    step(2);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!w_out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", int'(w_out_valid), 1);
  endtask

  initial begin
    int            s0;
    int            stable;
    logic [DW-1:0] sa, sb, sg, ra, rb;
    bit            rnd_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(w_out_valid), 0);
    check("rst_fifo_count", int'(w_fifo_count), 0);
    check("rst_core_start", int'(w_core_start), 0);
    check("rst_in_ready", int'(w_in_ready), 1);
    check("rst_busy", int'(w_busy), 0);
    check("rst_core_a", int'(w_core_a), 0);
    check("rst_out_gcd", int'(w_out_gcd), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // Single job.
    out_ready = 1'b1;
    s0 = starts;
    push(8'd12, 8'd18);
    wait_drain();
    check("single_starts", starts - s0, 1);

    // Burst into a full FIFO, then hold the first result under backpressure.
    out_ready = 1'b0;
    push(8'd12, 8'd18);
    push(8'd48, 8'd36);
    push(8'd7, 8'd5);
    push(8'd255, 8'd255);
    push(8'd100, 8'd75);
    @(negedge clk);
    check("full_in_ready", int'(w_in_ready), 0);
    check("full_count", int'(w_fifo_count), 4);
    wait_out_valid();
    sa = w_out_a;
    sb = w_out_b;
    sg = w_out_gcd;
    s0 = starts;
    stable = 1;
    repeat (50) begin
      @(negedge clk);
      if (!w_out_valid || w_out_a != sa || w_out_b != sb || w_out_gcd != sg) stable = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_start", starts - s0, 0);
    check("bp_head_gcd", int'(sg), 6);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(8'd81, 8'd27);
    wait_drain();
    check("bp_resumed", int'(starts - s0 >= 5), 1);

    // Zero operands.
    s0 = starts;
    push(8'd0, 8'd9);
    push(8'd0, 8'd0);
    wait_drain();
`ifdef GCD_DISPATCH_BYPASS_EN
    check("zero_starts", starts - s0, 0);
`else
    check("zero_starts", starts - s0, 2);
`endif

    // Reset during a long job with three pairs queued.
    push(8'd255, 8'd1);
    push(8'd3, 8'd6);
    push(8'd9, 8'd12);
    push(8'd5, 8'd10);
    step(5);
    @(negedge clk);
    check("pre_rst_count", int'(w_fifo_count), 3);
    check("pre_rst_busy", int'(w_busy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(1);
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", int'(w_out_valid), 0);
    check("mid_rst_count", int'(w_fifo_count), 0);
    check("mid_rst_core_start", int'(w_core_start), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(8'd14, 8'd21);
    wait_drain();

    // Push and pop on the same edge with two entries queued.
    out_ready = 1'b0;
    push(8'd6, 8'd3);
    push(8'd20, 8'd8);
    push(8'd9, 8'd27);
    wait_out_valid();
    check("pp_before", int'(w_fifo_count), 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(8'd35, 8'd14);
    @(negedge clk);
    check("pp_after", int'(w_fifo_count), 2);
    step(1);
    wait_drain();

    // Randomized traffic with random sink backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(1, 255));
          if ($urandom_range(0, 5) == 0) ra = '0;
          if ($urandom_range(0, 7) == 0) rb = '0;
          push(ra, rb);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("end_busy", int'(w_busy), 0);
    check("end_out_valid", int'(w_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
